// File: rtl/dsi_pkt_pkg.sv
// Shared codes, FSM states and sizing helper for the DSI line packet scheduler.
package dsi_pkt_pkg;

    localparam logic [2:0] PktHss   = 3'd1;
    localparam logic [2:0] PktBlp   = 3'd2;
    localparam logic [2:0] PktVideo = 3'd3;
    localparam logic [2:0] PktVss   = 3'd4;

    localparam logic [7:0] CtrlDeValid   = 8'hFF;
    localparam logic [7:0] CtrlDeInvalid = 8'h0F;
    localparam logic [7:0] CtrlVs        = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StRdCtrl,
        StTxHss,
        StTxBlp,
        StTxVideo
    } dsi_state_e;

    function automatic int unsigned dsi_beats(input int unsigned h_active,
                                              input int unsigned bpp,
                                              input int unsigned lanes);
        return (h_active * bpp) / (8 * lanes);
    endfunction

endpackage

// File: rtl/dsi_lane_unpack.sv
// One lane's 16->8 unpacker: low byte straight from the FIFO head, high byte held for the odd beat.
module dsi_lane_unpack (
    input  logic        I_lcd_clk,
    input  logic        I_rst_n,
    input  logic [15:0] I_word,
    input  logic        I_load,
    input  logic        I_odd,
    output logic [7:0]  O_byte
);

    logic [7:0] hi_q, hi_d;

    always_comb begin
        hi_d = hi_q;
        if (I_load) begin
            hi_d = I_word[15:8];
        end
    end

    always_ff @(posedge I_lcd_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

    assign O_byte = I_odd ? hi_q : I_word[7:0];

endmodule

// File: rtl/dsi_line_pkt_sched.sv
// DSI video-mode line scheduler: decodes sync tokens, emits HSS/VSS requests, optional BLP
// long packet and multi-lane line payload, with pixel-FIFO underflow abort.
module dsi_line_pkt_sched
    import dsi_pkt_pkg::*;
#(
    parameter int unsigned LANES           = 4,
    parameter int unsigned H_ACTIVE        = 1080,
    parameter int unsigned BPP             = 24,
    parameter int unsigned BLP_LEN         = 15,
    parameter logic [31:0] BLP_HDR         = 32'h2A003619,
    parameter logic [15:0] BLP_CRC         = 16'h6D1C,
    parameter logic [7:0]  CTRL_DE_VALID   = CtrlDeValid,
    parameter logic [7:0]  CTRL_DE_INVALID = CtrlDeInvalid,
    parameter logic [7:0]  CTRL_VS         = CtrlVs
) (
    input  logic                  I_lcd_clk,
    input  logic                  I_rst_n,
    input  logic                  I_blp_en,
    input  logic                  I_empty_vshsde,
    input  logic [7:0]            I_vshsde_ctrl,
    output logic                  O_vshsde_rden,
    input  logic [LANES-1:0]      I_empty,
    input  logic [16*LANES-1:0]   I_rgb_data,
    output logic                  O_rgb_rden,
    output logic [8*LANES-1:0]    O_lcd_data,
    output logic                  O_lcd_de,
    output logic [2:0]            O_pkt_type,
    output logic                  O_pkt_flag,
    output logic                  O_valid_data_flag,
    output logic                  O_underflow,
    output logic [15:0]           O_underflow_cnt,
    output logic                  O_err_ctrl
);

    localparam int unsigned BEATS     = dsi_beats(H_ACTIVE, BPP, LANES);
    localparam int unsigned BLP_BYTES = BLP_LEN * LANES;
    localparam int unsigned MAX_BEATS = (BEATS > BLP_LEN) ? BEATS : BLP_LEN;
    localparam int unsigned BW        = $clog2(MAX_BEATS);

    dsi_state_e          state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [2:0]          type_q, type_d;
    logic                flag_q, flag_d;
    logic                valid_q, valid_d;
    logic                de_q, de_d;
    logic [8*LANES-1:0]  data_q, data_d;
    logic                ctrl_rden_q, ctrl_rden_d;
    logic                uf_q, uf_d;
    logic [15:0]         uf_cnt_q, uf_cnt_d;
    logic                err_q, err_d;
    logic                blp_en_q, blp_en_d;

    logic                rgb_rden;
    logic                any_empty;
    logic [8*LANES-1:0]  vid_data;
    logic [8*LANES-1:0]  blp_data;

    function automatic logic [7:0] blp_byte(input int unsigned k);
        logic [7:0] b;
        if (k < 4) begin
            unique case (k[1:0])
                2'd0: b = BLP_HDR[7:0];
                2'd1: b = BLP_HDR[15:8];
                2'd2: b = BLP_HDR[23:16];
                2'd3: b = BLP_HDR[31:24];
            endcase
        end else if (k == BLP_BYTES - 2) begin
            b = BLP_CRC[7:0];
        end else if (k == BLP_BYTES - 1) begin
            b = BLP_CRC[15:8];
        end else begin
            b = 8'h55;
        end
        return b;
    endfunction

    always_comb begin
        blp_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            blp_data[8*l +: 8] = blp_byte(32'(beat_q) * LANES + l);
        end
    end

    assign any_empty = (I_empty != '0);
    assign rgb_rden  = (state_q == StTxVideo) && !beat_q[0] && !any_empty;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dsi_lane_unpack u_unpack (
            .I_lcd_clk (I_lcd_clk),
            .I_rst_n   (I_rst_n),
            .I_word    (I_rgb_data[16*l +: 16]),
            .I_load    (rgb_rden),
            .I_odd     (beat_q[0]),
            .O_byte    (vid_data[8*l +: 8])
        );
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        type_d      = type_q;
        flag_d      = 1'b0;
        valid_d     = valid_q;
        de_d        = 1'b0;
        data_d      = '0;
        ctrl_rden_d = 1'b0;
        uf_d        = 1'b0;
        uf_cnt_d    = uf_cnt_q;
        err_d       = 1'b0;
        blp_en_d    = blp_en_q;

        unique case (state_q)
            StIdle: begin
                type_d  = '0;
                valid_d = 1'b0;
                beat_d  = '0;
                if (!I_empty_vshsde) begin
                    ctrl_rden_d = 1'b1;
                    state_d     = StRdCtrl;
                end
            end
            StRdCtrl: begin
                // Token lands on the bus the cycle after the read strobe is seen.
                if (!ctrl_rden_q) begin
                    blp_en_d = I_blp_en;
                    state_d  = StIdle;
                    if (I_vshsde_ctrl == CTRL_DE_VALID) begin
                        type_d  = PktHss;
                        flag_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = StTxHss;
                    end else if (I_vshsde_ctrl == CTRL_DE_INVALID) begin
                        type_d = PktHss;
                        flag_d = 1'b1;
                    end else if (I_vshsde_ctrl == CTRL_VS) begin
                        type_d = PktVss;
                        flag_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StTxHss: begin
                flag_d = 1'b1;
                beat_d = '0;
                if (blp_en_q) begin
                    type_d  = PktBlp;
                    state_d = StTxBlp;
                end else begin
                    type_d  = PktVideo;
                    state_d = StTxVideo;
                end
            end
            StTxBlp: begin
                type_d = PktBlp;
                de_d   = 1'b1;
                data_d = blp_data;
                flag_d = (beat_q == '0);
                if (beat_q == BW'(BLP_LEN - 1)) begin
                    beat_d  = '0;
                    state_d = StTxVideo;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            StTxVideo: begin
                type_d = PktVideo;
                if (!beat_q[0] && any_empty) begin
                    // Rest of the line is dropped; upstream has to resync.
                    uf_d    = 1'b1;
                    state_d = StIdle;
                    if (uf_cnt_q != 16'hFFFF) begin
                        uf_cnt_d = uf_cnt_q + 16'd1;
                    end
                end else begin
                    de_d   = 1'b1;
                    data_d = vid_data;
                    flag_d = (beat_q == '0);
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_lcd_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            type_q      <= '0;
            flag_q      <= 1'b0;
            valid_q     <= 1'b0;
            de_q        <= 1'b0;
            data_q      <= '0;
            ctrl_rden_q <= 1'b0;
            uf_q        <= 1'b0;
            uf_cnt_q    <= '0;
            err_q       <= 1'b0;
            blp_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            type_q      <= type_d;
            flag_q      <= flag_d;
            valid_q     <= valid_d;
            de_q        <= de_d;
            data_q      <= data_d;
            ctrl_rden_q <= ctrl_rden_d;
            uf_q        <= uf_d;
            uf_cnt_q    <= uf_cnt_d;
            err_q       <= err_d;
            blp_en_q    <= blp_en_d;
        end
    end

    assign O_vshsde_rden     = ctrl_rden_q;
    assign O_rgb_rden        = rgb_rden;
    assign O_lcd_data        = data_q;
    assign O_lcd_de          = de_q;
    assign O_pkt_type        = type_q;
    assign O_pkt_flag        = flag_q;
    assign O_valid_data_flag = valid_q;
    assign O_underflow       = uf_q;
    assign O_underflow_cnt   = uf_cnt_q;
    assign O_err_ctrl        = err_q;

endmodule

// File: tb/tb_dsi_line_pkt_sched.sv
// Directed bench: 4-lane instance for BLP/video/token/reset cases, 2-lane instance for underflow.
`timescale 1ns/1ps
module tb_dsi_line_pkt_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- instance A: 4 lanes ----------------
    logic        blp_en_a = 1'b0;
    logic        empty_ctrl_a;
    logic [7:0]  ctrl_a;
    logic        ctrl_rden_a;
    logic [3:0]  empty_a = 4'h0;
    logic [63:0] rgb_a;
    logic        rgb_rden_a;
    logic [31:0] data_a;
    logic        de_a, flag_a, valid_a, uf_a, err_a;
    logic [2:0]  type_a;
    logic [15:0] uf_cnt_a;
    logic [7:0]  tok_a [0:15];
    int          wr_a = 0, rd_a = 0, rdcnt_a = 0, decnt_a = 0;

    assign empty_ctrl_a = (wr_a == rd_a);

    always @(posedge clk) begin
        if (ctrl_rden_a && rd_a != wr_a) begin
            ctrl_a <= tok_a[rd_a];
            rd_a   <= rd_a + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdcnt_a <= 0;
        else if (rgb_rden_a) rdcnt_a <= rdcnt_a + 1;
    end

    always_comb begin
        rgb_a = '0;
        for (int n = 0; n < 4; n++) begin
            rgb_a[16*n +: 16] = {8'(16*n + 2*rdcnt_a + 1), 8'(16*n + 2*rdcnt_a)};
        end
    end

    always @(negedge clk) if (de_a) decnt_a <= decnt_a + 1;

    dsi_line_pkt_sched #(
        .LANES    (4),
        .H_ACTIVE (8),
        .BPP      (24),
        .BLP_LEN  (15)
    ) u_dut_a (
        .I_lcd_clk         (clk),
        .I_rst_n           (rst_n),
        .I_blp_en          (blp_en_a),
        .I_empty_vshsde    (empty_ctrl_a),
        .I_vshsde_ctrl     (ctrl_a),
        .O_vshsde_rden     (ctrl_rden_a),
        .I_empty           (empty_a),
        .I_rgb_data        (rgb_a),
        .O_rgb_rden        (rgb_rden_a),
        .O_lcd_data        (data_a),
        .O_lcd_de          (de_a),
        .O_pkt_type        (type_a),
        .O_pkt_flag        (flag_a),
        .O_valid_data_flag (valid_a),
        .O_underflow       (uf_a),
        .O_underflow_cnt   (uf_cnt_a),
        .O_err_ctrl        (err_a)
    );

    // ---------------- instance B: 2 lanes, underflow ----------------
    logic        blp_en_b = 1'b0;
    logic        empty_ctrl_b;
    logic [7:0]  ctrl_b;
    logic        ctrl_rden_b;
    logic [1:0]  empty_b;
    logic [31:0] rgb_b;
    logic        rgb_rden_b;
    logic [15:0] data_b;
    logic        de_b, flag_b, valid_b, uf_b, err_b;
    logic [2:0]  type_b;
    logic [15:0] uf_cnt_b;
    logic [7:0]  tok_b [0:15];
    int          wr_b = 0, rd_b = 0, rdcnt_b = 0, viol_b = 0;
    logic        uf_mode_b = 1'b1;

    assign empty_ctrl_b = (wr_b == rd_b);
    assign empty_b      = {uf_mode_b && (rdcnt_b >= 2), 1'b0};

    always @(posedge clk) begin
        if (ctrl_rden_b && rd_b != wr_b) begin
            ctrl_b <= tok_b[rd_b];
            rd_b   <= rd_b + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdcnt_b <= 0;
        else if (rgb_rden_b) rdcnt_b <= rdcnt_b + 1;
    end

    always_comb begin
        rgb_b = '0;
        for (int n = 0; n < 2; n++) begin
            rgb_b[16*n +: 16] = {8'(16*n + 2*rdcnt_b + 1), 8'(16*n + 2*rdcnt_b)};
        end
    end

    always @(negedge clk) if (rgb_rden_b && empty_b != 2'b00) viol_b <= viol_b + 1;

    dsi_line_pkt_sched #(
        .LANES    (2),
        .H_ACTIVE (8),
        .BPP      (24),
        .BLP_LEN  (15)
    ) u_dut_b (
        .I_lcd_clk         (clk),
        .I_rst_n           (rst_n),
        .I_blp_en          (blp_en_b),
        .I_empty_vshsde    (empty_ctrl_b),
        .I_vshsde_ctrl     (ctrl_b),
        .O_vshsde_rden     (ctrl_rden_b),
        .I_empty           (empty_b),
        .I_rgb_data        (rgb_b),
        .O_rgb_rden        (rgb_rden_b),
        .O_lcd_data        (data_b),
        .O_lcd_de          (de_b),
        .O_pkt_type        (type_b),
        .O_pkt_flag        (flag_b),
        .O_valid_data_flag (valid_b),
        .O_underflow       (uf_b),
        .O_underflow_cnt   (uf_cnt_b),
        .O_err_ctrl        (err_b)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // BLP bytes for header 2A003619, crc 6D1C, 60-byte packet
    function automatic logic [7:0] exp_blp_byte(input int k);
        logic [7:0] b;
        case (k)
            0:       b = 8'h19;
            1:       b = 8'h36;
            2:       b = 8'h00;
            3:       b = 8'h2A;
            58:      b = 8'h1C;
            59:      b = 8'h6D;
            default: b = 8'h55;
        endcase
        return b;
    endfunction

    task automatic push_a(input logic [7:0] t);
        tok_a[wr_a] = t;
        wr_a++;
    endtask

    task automatic push_b(input logic [7:0] t);
        tok_b[wr_b] = t;
        wr_b++;
    endtask

    task automatic run_line_a(input bit blp);
        logic [31:0] v;
        int          r0;
        int          i;
        i = 0;
        while (!flag_a && i < 30) begin
            @(negedge clk);
            i++;
        end
        check("hss_flag", flag_a, 1);
        check("hss_type", type_a, 1);
        check("hss_valid", valid_a, 1);
        r0 = rdcnt_a;
        @(negedge clk);
        check("hss2_flag", flag_a, 1);
        check("hss2_type", type_a, blp ? 2 : 3);
        check("hss2_de", de_a, 0);
        if (blp) begin
            for (int b = 0; b < 15; b++) begin
                @(negedge clk);
                for (int n = 0; n < 4; n++) v[8*n +: 8] = exp_blp_byte(b*4 + n);
                check("blp_de", de_a, 1);
                check("blp_data", data_a, v);
                check("blp_flag", flag_a, (b == 0));
                check("blp_type", type_a, 2);
            end
        end
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) v[8*n +: 8] = 8'(16*n + 2*r0 + b);
            check("vid_de", de_a, 1);
            check("vid_data", data_a, v);
            check("vid_flag", flag_a, (b == 0));
            check("vid_type", type_a, 3);
        end
        @(negedge clk);
        check("eol_de", de_a, 0);
        check("eol_valid", valid_a, 0);
        check("rden_cnt", rdcnt_a - r0, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          i;
        int          de0;
        logic [15:0] vb;

        repeat (3) @(negedge clk);
        check("rst_flag", flag_a, 0);
        check("rst_type", type_a, 0);
        check("rst_de", de_a, 0);
        check("rst_data", data_a, 0);
        check("rst_ctrl_rden", ctrl_rden_a, 0);
        check("rst_rgb_rden", rgb_rden_a, 0);
        check("rst_uf_cnt", uf_cnt_a, 0);
        check("rst_err", err_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // FF with BLP
        blp_en_a = 1'b1;
        push_a(8'hFF);
        run_line_a(1'b1);

        // 0F then F0, exact accept latency on the first token
        de0 = decnt_a;
        push_a(8'h0F);
        push_a(8'hF0);
        @(negedge clk);
        check("tok_rden", ctrl_rden_a, 1);
        @(negedge clk);
        check("tok_rden_pulse", ctrl_rden_a, 0);
        check("tok_flag_early", flag_a, 0);
        @(negedge clk);
        check("inv_flag", flag_a, 1);
        check("inv_type", type_a, 1);
        check("inv_valid", valid_a, 0);
        @(negedge clk);
        check("inv_flag_clr", flag_a, 0);
        i = 0;
        while (!flag_a && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("vs_flag", flag_a, 1);
        check("vs_type", type_a, 4);
        check("vs_valid", valid_a, 0);
        @(negedge clk);
        check("vs_flag_clr", flag_a, 0);
        check("tok_no_de", decnt_a - de0, 0);

        // FF without BLP
        blp_en_a = 1'b0;
        push_a(8'hFF);
        run_line_a(1'b0);

        // unknown token, then a normal line
        blp_en_a = 1'b1;
        push_a(8'h3C);
        push_a(8'hFF);
        i = 0;
        while (!err_a && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("err_pulse", err_a, 1);
        check("err_no_flag", flag_a, 0);
        @(negedge clk);
        check("err_clr", err_a, 0);
        run_line_a(1'b1);

        // reset in the middle of video
        push_a(8'hFF);
        i = 0;
        while (!(de_a && type_a == 3'd3) && i < 60) begin
            @(negedge clk);
            i++;
        end
        check("mid_video", de_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_de", de_a, 0);
        check("arst_flag", flag_a, 0);
        check("arst_type", type_a, 0);
        check("arst_valid", valid_a, 0);
        check("arst_rgb_rden", rgb_rden_a, 0);
        check("arst_data", data_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_a(8'hFF);
        run_line_a(1'b1);

        // instance B: underflow at video beat 4
        push_b(8'hFF);
        i = 0;
        while (!flag_b && i < 30) begin
            @(negedge clk);
            i++;
        end
        check("b_hss_type", type_b, 1);
        @(negedge clk);
        check("b_vid_flag", flag_b, 1);
        check("b_vid_type", type_b, 3);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) vb[8*n +: 8] = 8'(16*n + b);
            check("b_de", de_b, 1);
            check("b_data", data_b, vb);
        end
        @(negedge clk);
        check("uf_de", de_b, 0);
        check("uf_pulse", uf_b, 1);
        check("uf_cnt", uf_cnt_b, 1);
        @(negedge clk);
        check("uf_pulse_clr", uf_b, 0);
        check("uf_cnt_hold", uf_cnt_b, 1);
        check("uf_valid", valid_b, 0);
        check("uf_rd", rdcnt_b, 2);
        check("uf_no_rden_empty", viol_b, 0);
        uf_mode_b = 1'b0;
        push_b(8'h0F);
        i = 0;
        while (!flag_b && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("b_idle_flag", flag_b, 1);
        check("b_idle_type", type_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
